adder_requester: RTL and testbench

ADDER_REQUESTER -- requirements
Module: adder_requester

---
 rtl/adder_requester.sv | 132 +++++++++++++
 tb/tb_adder_requester.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/adder_requester.sv
// rtl/adder_requester.sv - request/response front end for a self-timed adder
// Launches one add with an F pulse, waits for the sticky ready flag or a timeout, holds the result.
module adder_requester #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_cin,
  output logic             F,
  output logic [WIDTH-1:0] adder_a,
  output logic [WIDTH-1:0] adder_b,
  output logic             adder_cin,
  input  logic [WIDTH-1:0] adder_sum,
  input  logic             adder_cout,
  input  logic             adder_R,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_timeout,
  output logic [3:0]       rsp_cycles,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_HOLD
  } state_t;

  localparam logic [3:0] LP_TIMEOUT = 4'(TIMEOUT);

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_wait_cnt;
  logic [WIDTH-1:0] r_adder_a;
  logic [WIDTH-1:0] r_adder_b;
  logic             r_adder_cin;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_cout;
  logic             r_rsp_timeout;
  logic [3:0]       r_rsp_cycles;

  logic             w_accept;
  logic             w_done;
  logic             w_expired;

  assign w_accept = (r_state == S_IDLE) && req_valid;
  // The flag is still the previous operation's on the first WAIT cycle, so it is blanked there.
  assign w_done    = (r_state == S_WAIT) && (r_wait_cnt != 4'd0) && adder_R;
  assign w_expired = (r_state == S_WAIT) && (r_wait_cnt == LP_TIMEOUT) && !adder_R;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (req_valid) w_next_state = S_LAUNCH;
      S_LAUNCH: w_next_state = S_WAIT;
      S_WAIT:   if (w_done || w_expired) w_next_state = S_HOLD;
      S_HOLD:   if (rsp_ready) w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_adder_a   <= '0;
      r_adder_b   <= '0;
      r_adder_cin <= 1'b0;
    end else if (w_accept) begin
      r_adder_a   <= req_a;
      r_adder_b   <= req_b;
      r_adder_cin <= req_cin;
    end
  end

  // Counter stops when WAIT is left, so it never advances past TIMEOUT.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= 4'd0;
    end else if (r_state == S_LAUNCH) begin
      r_wait_cnt <= 4'd0;
    end else if ((r_state == S_WAIT) && !w_done && !w_expired) begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_sum     <= '0;
      r_rsp_cout    <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_rsp_cycles  <= 4'd0;
    end else if (w_done) begin
      r_rsp_sum     <= adder_sum;
      r_rsp_cout    <= adder_cout;
      r_rsp_timeout <= 1'b0;
      r_rsp_cycles  <= r_wait_cnt;
    end else if (w_expired) begin
      r_rsp_sum     <= '0;
      r_rsp_cout    <= 1'b0;
      r_rsp_timeout <= 1'b1;
      r_rsp_cycles  <= LP_TIMEOUT;
    end
  end

  assign req_ready   = (r_state == S_IDLE);
  assign F           = (r_state == S_LAUNCH);
  assign rsp_valid   = (r_state == S_HOLD);
  assign busy        = (r_state != S_IDLE);
  assign adder_a     = r_adder_a;
  assign adder_b     = r_adder_b;
  assign adder_cin   = r_adder_cin;
  assign rsp_sum     = r_rsp_sum;
  assign rsp_cout    = r_rsp_cout;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_cycles  = r_rsp_cycles;

endmodule

// File: tb/tb_adder_requester.sv
// tb/tb_adder_requester.sv - directed bench for adder_requester
// Adder behaviour is played from the stimulus sequence, one WAIT cycle at a time.
module tb_adder_requester;

  localparam int WIDTH = 32;
  localparam logic [WIDTH-1:0] JUNK = 32'hDEAD_BEEF;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             req_cin;
  logic             F;
  logic [WIDTH-1:0] adder_a;
  logic [WIDTH-1:0] adder_b;
  logic             adder_cin;
  logic [WIDTH-1:0] adder_sum;
  logic             adder_cout;
  logic             adder_R;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_sum;
  logic             rsp_cout;
  logic             rsp_timeout;
  logic [3:0]       rsp_cycles;
  logic             busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  adder_requester #(.WIDTH(WIDTH), .TIMEOUT(15)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .F          (F),
    .adder_a    (adder_a),
    .adder_b    (adder_b),
    .adder_cin  (adder_cin),
    .adder_sum  (adder_sum),
    .adder_cout (adder_cout),
    .adder_R    (adder_R),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_sum    (rsp_sum),
    .rsp_cout   (rsp_cout),
    .rsp_timeout(rsp_timeout),
    .rsp_cycles (rsp_cycles),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // delay = WAIT count at which the adder raises R (>15 means never); stale keeps R high at count 0.
  task automatic run_txn(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic cin,
                         input int delay, input bit stale, input int hold,
                         input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int  exp_cycles;
    bit  exp_to;
    bit  r;
    exp_to     = (delay > 15);
    exp_cycles = exp_to ? 15 : delay;

    check("idle_req_ready", 64'(req_ready), 64'd1);
    req_valid = 1'b1;
    req_a     = a;
    req_b     = b;
    req_cin   = cin;
    @(negedge clk);
    req_valid = 1'b0;
    req_a     = ~a;
    req_b     = ~b;
    req_cin   = ~cin;
    check("launch_F", 64'(F), 64'd1);
    check("launch_req_ready", 64'(req_ready), 64'd0);
    check("launch_busy", 64'(busy), 64'd1);
    check("launch_adder_a", 64'(adder_a), 64'(a));
    check("launch_adder_b", 64'(adder_b), 64'(b));
    check("launch_adder_cin", 64'(adder_cin), 64'(cin));
    if (stale) adder_R = 1'b1;

    for (int k = 0; k <= exp_cycles; k++) begin
      @(negedge clk);
      check("wait_F", 64'(F), 64'd0);
      check("wait_rsp_valid", 64'(rsp_valid), 64'd0);
      r          = (k == 0) ? stale : (k >= delay);
      adder_R    = r;
      adder_sum  = (r && k > 0) ? exp_sum : JUNK;
      adder_cout = (r && k > 0) ? exp_cout : 1'b1;
    end

    @(negedge clk);
    adder_sum  = JUNK;
    adder_cout = ~exp_cout;
    check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
    check("hold_rsp_sum", 64'(rsp_sum), 64'(exp_sum));
    check("hold_rsp_cout", 64'(rsp_cout), 64'(exp_cout));
    check("hold_rsp_cycles", 64'(rsp_cycles), 64'(exp_cycles));
    check("hold_rsp_timeout", 64'(rsp_timeout), 64'(exp_to));
    check("hold_adder_a", 64'(adder_a), 64'(a));

    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("stall_rsp_valid", 64'(rsp_valid), 64'd1);
      check("stall_req_ready", 64'(req_ready), 64'd0);
      check("stall_rsp_sum", 64'(rsp_sum), 64'(exp_sum));
      check("stall_rsp_cycles", 64'(rsp_cycles), 64'(exp_cycles));
    end

    // Offer a request in the handshake cycle: it must not be taken.
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("post_rsp_valid", 64'(rsp_valid), 64'd0);
    check("post_req_ready", 64'(req_ready), 64'd1);
    check("post_no_bypass_F", 64'(F), 64'd0);
    check("post_adder_a", 64'(adder_a), 64'(a));
    check("post_rsp_sum", 64'(rsp_sum), 64'(exp_sum));
  endtask

  initial begin
    reset_n    = 1'b0;
    req_valid  = 1'b0;
    req_a      = '0;
    req_b      = '0;
    req_cin    = 1'b0;
    adder_sum  = JUNK;
    adder_cout = 1'b0;
    adder_R    = 1'b0;
    rsp_ready  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_F", 64'(F), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    check("rst_adder_a", 64'(adder_a), 64'd0);
    check("rst_rsp_cycles", 64'(rsp_cycles), 64'd0);
    reset_n = 1'b1;
    @(negedge clk);

    run_txn(32'h0000_0005, 32'h0000_0003, 1'b0, 4,   1'b0, 0,  32'h0000_0008, 1'b0);
    run_txn(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 9,   1'b0, 0,  32'h0000_0000, 1'b1);
    run_txn(32'h1234_5678, 32'h1111_1111, 1'b1, 4,   1'b1, 0,  32'h2345_678A, 1'b0);
    run_txn(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, 99,  1'b0, 0,  32'h0000_0000, 1'b0);
    run_txn(32'h8000_0000, 32'h8000_0000, 1'b1, 15,  1'b0, 0,  32'h0000_0001, 1'b1);
    run_txn(32'h0000_0007, 32'h0000_0008, 1'b1, 2,   1'b0, 10, 32'h0000_0010, 1'b0);
    run_txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1,   1'b0, 0,  32'hFFFF_FFFF, 1'b1);

    // Abort mid-WAIT with reset.
    req_valid = 1'b1;
    req_a     = 32'h0000_00AA;
    req_b     = 32'h0000_0055;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    adder_R = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_busy_before", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("abort_F", 64'(F), 64'd0);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_adder_a", 64'(adder_a), 64'd0);
    check("abort_rsp_sum", 64'(rsp_sum), 64'd0);
    check("abort_rsp_cout", 64'(rsp_cout), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("after_abort_rsp_valid", 64'(rsp_valid), 64'd0);
      check("after_abort_req_ready", 64'(req_ready), 64'd1);
    end
    run_txn(32'h0000_0064, 32'h0000_00C8, 1'b0, 3,   1'b0, 0,  32'h0000_012C, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
